// File: rtl/clock_period_meter_pkg.sv
// Shared definitions for the clock period meter: FSM encoding and parameter defaults.
package clock_period_meter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_MEAS = 2'd2
    } state_t;

    localparam int DEF_CNT_W       = 16;
    localparam int DEF_SYNC_STAGES = 2;

endpackage

// File: rtl/clock_period_meter_edge_sync.sv
// Synchronizer chain for an asynchronous level, followed by one history flop
// that produces single-cycle rise/fall strobes in the clk domain.
module edge_sync
    import clock_period_meter_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic clk,
    input  logic reset,
    input  logic i_async,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_level = r_sync[SYNC_STAGES-1];
    assign o_rise  = o_level & ~r_prev;
    assign o_fall  = ~o_level & r_prev;

endmodule

// File: rtl/clock_period_meter.sv
// Measures period and high time of a slow clock in clk cycles, pulses meas_valid
// once per slow period and flags a slow clock that has stopped toggling.
module clock_period_meter
    import clock_period_meter_pkg::*;
#(
    parameter int CNT_W       = DEF_CNT_W,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             slow_clk_in,
    input  logic             enable,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             meas_valid,
    output logic             stuck
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           r_state;
    state_t           w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_hi_cap;
    logic             w_level;
    logic             w_rise;
    logic             w_fall;
    logic             w_cnt_full;
    logic             w_start;
    logic             w_capture;
    logic             w_saturate;
    logic             w_unused;

    edge_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_edge_sync (
        .clk    (clk),
        .reset  (reset),
        .i_async(slow_clk_in),
        .o_level(w_level),
        .o_rise (w_rise),
        .o_fall (w_fall)
    );

    // The synchronized level is only needed by other users of edge_sync.
    assign w_unused   = w_level;
    assign w_cnt_full = (r_cnt == CNT_MAX);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        w_capture    = 1'b0;
        w_saturate   = 1'b0;
        if (!enable) begin
            w_state_next = ST_IDLE;
        end else begin
            unique case (r_state)
                ST_IDLE: w_state_next = ST_ARM;
                ST_ARM: begin
                    if (w_rise) begin
                        w_state_next = ST_MEAS;
                        w_start      = 1'b1;
                    end
                end
                ST_MEAS: begin
                    if (w_rise) begin
                        w_capture = 1'b1;
                    end else if (w_cnt_full) begin
                        w_state_next = ST_ARM;
                        w_saturate   = 1'b1;
                    end
                end
                default: w_state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt      <= '0;
            r_hi_cap   <= '0;
            period     <= '0;
            high_time  <= '0;
            meas_valid <= 1'b0;
            stuck      <= 1'b0;
        end else begin
            meas_valid <= w_capture;
            if (w_start || w_capture) begin
                r_cnt    <= CNT_ONE;
                r_hi_cap <= '0;
            end else if (enable && r_state == ST_MEAS) begin
                if (!w_cnt_full) begin
                    r_cnt <= r_cnt + CNT_ONE;
                end
                // A later fall in the same period overwrites an earlier one.
                if (w_fall) begin
                    r_hi_cap <= r_cnt;
                end
            end
            if (w_capture) begin
                period    <= r_cnt;
                high_time <= r_hi_cap;
            end
            if (w_saturate) begin
                stuck <= 1'b1;
            end else if (!enable || w_rise) begin
                stuck <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_clock_period_meter.sv
// Bench for clock_period_meter: a timestamp-based model predicts every output each
// cycle for a 16-bit and a 4-bit instance; directed phases pin key values by hand.
module tb_clock_period_meter;

    localparam int SYNC = 2;
    localparam int M_IDLE = 0;
    localparam int M_ARM  = 1;
    localparam int M_MEAS = 2;

    typedef struct {
        int mode;
        int t_rise;
        int t_fall;
        int period;
        int high;
        bit valid;
        bit stuck;
    } model_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        slow_clk_in;
    logic        enable;
    logic [15:0] per16, hi16;
    logic        v16, st16;
    logic [3:0]  per4, hi4;
    logic        v4, st4;

    int n_checks = 0;
    int n_errors = 0;
    int pulse16 = 0;
    int pulse4 = 0;
    int last_per16 = 0, last_hi16 = 0, last_per4 = 0, last_hi4 = 0;
    bit model_live = 1'b0;
    int k = 0;
    bit hq [0:SYNC];
    model_t m16, m4;

    clock_period_meter #(.CNT_W(16), .SYNC_STAGES(SYNC)) dut16 (
        .clk(clk), .reset(reset), .slow_clk_in(slow_clk_in), .enable(enable),
        .period(per16), .high_time(hi16), .meas_valid(v16), .stuck(st16)
    );

    clock_period_meter #(.CNT_W(4), .SYNC_STAGES(SYNC)) dut4 (
        .clk(clk), .reset(reset), .slow_clk_in(slow_clk_in), .enable(enable),
        .period(per4), .high_time(hi4), .meas_valid(v4), .stuck(st4)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Rules in terms of edge timestamps: period is the distance between detected
    // rises, high time the distance from a rise to the last fall before the next rise.
    function automatic model_t model_step(input model_t m, input bit rst, input bit en,
                                          input bit s, input bit p, input int t, input int cmax);
        model_t n = m;
        if (rst) begin
            n = '{mode: M_IDLE, t_rise: 0, t_fall: -1, period: 0, high: 0, valid: 1'b0, stuck: 1'b0};
            return n;
        end
        n.valid = 1'b0;
        if (!en) begin
            n.mode  = M_IDLE;
            n.stuck = 1'b0;
            return n;
        end
        case (m.mode)
            M_IDLE: n.mode = M_ARM;
            M_ARM: begin
                if (s && !p) begin
                    n.mode   = M_MEAS;
                    n.t_rise = t;
                    n.t_fall = -1;
                    n.stuck  = 1'b0;
                end
            end
            default: begin
                if (s && !p) begin
                    n.period = t - m.t_rise;
                    n.high   = (m.t_fall < 0) ? 0 : m.t_fall - m.t_rise;
                    n.valid  = 1'b1;
                    n.t_rise = t;
                    n.t_fall = -1;
                end else if (t - m.t_rise >= cmax) begin
                    n.stuck = 1'b1;
                    n.mode  = M_ARM;
                end else if (!s && p) begin
                    n.t_fall = t;
                end
            end
        endcase
        return n;
    endfunction

    // Model: hq[i] holds the slow clock as sampled i+1 edges ago.
    always @(posedge clk) begin
        bit s, p;
        s  = hq[SYNC-1];
        p  = hq[SYNC];
        m16 = model_step(m16, reset, enable, s, p, k, 65535);
        m4  = model_step(m4, reset, enable, s, p, k, 15);
        if (reset) begin
            for (int i = 0; i <= SYNC; i++) hq[i] = 1'b0;
            model_live = 1'b1;
        end else begin
            for (int i = SYNC; i > 0; i--) hq[i] = hq[i-1];
            hq[0] = slow_clk_in;
        end
        k++;
    end

    // Compare process: every cycle once the model has seen a reset.
    always @(posedge clk) begin
        #1;
        if (model_live) begin
            check("dut16 period", per16, m16.period);
            check("dut16 high_time", hi16, m16.high);
            check("dut16 meas_valid", v16, m16.valid);
            check("dut16 stuck", st16, m16.stuck);
            check("dut4 period", per4, m4.period);
            check("dut4 high_time", hi4, m4.high);
            check("dut4 meas_valid", v4, m4.valid);
            check("dut4 stuck", st4, m4.stuck);
            if (v16) begin
                pulse16++;
                last_per16 = per16;
                last_hi16  = hi16;
            end
            if (v4) begin
                pulse4++;
                last_per4 = per4;
                last_hi4  = hi4;
            end
        end
    end

    task automatic hold(input logic v, input int n);
        slow_clk_in = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic gen(input int hi, input int lo, input int nper);
        repeat (nper) begin
            hold(1'b1, hi);
            hold(1'b0, lo);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int p0, sp, sh, p4, stuck_at;
        reset = 1'b1;
        enable = 1'b0;
        slow_clk_in = 1'b0;
        repeat (3) @(negedge clk);
        check("reset period", per16, 0);
        check("reset high_time", hi16, 0);
        check("reset meas_valid", v16, 0);
        check("reset stuck", st16, 0);
        reset = 1'b0;
        hold(1'b0, 2);
        enable = 1'b1;
        hold(1'b0, 2);

        // 50% duty at clk/10: first rise only arms the count.
        gen(5, 5, 1);
        check("t1 no pulse on first rise", pulse16, 0);
        gen(5, 5, 1);
        check("t1 pulse on second rise", pulse16, 1);
        check("t1 period", last_per16, 10);
        check("t1 high_time", last_hi16, 5);
        gen(5, 5, 3);
        check("t1 pulse count", pulse16, 4);
        check("t1 steady period", last_per16, 10);
        check("t1 steady high_time", last_hi16, 5);

        // Duty change: 3/7, then 6/6.
        gen(3, 7, 3);
        check("t2 pulse count", pulse16, 7);
        check("t2 period 3/7", last_per16, 10);
        check("t2 high 3/7", last_hi16, 3);
        gen(6, 6, 2);
        check("t2 period 6/6", last_per16, 12);
        check("t2 high 6/6", last_hi16, 6);
        check("t2 dut4 period", last_per4, 12);

        // Slow clock stops low: 4-bit instance saturates.
        stuck_at = 0;
        p4 = 0;
        slow_clk_in = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            if (i == 6) slow_clk_in = 1'b0;
            @(negedge clk);
            if (i == 5) p4 = pulse4;
            if (st4 && stuck_at == 0) begin
                stuck_at = i;
                break;
            end
        end
        check("t3 stuck latency", stuck_at, 18);
        check("t3 no pulse when stuck", pulse4, p4);
        check("t3 period holds", per4, 12);
        gen(5, 5, 1);
        check("t3 stuck cleared", st4, 0);
        check("t3 no pulse on first rise", pulse4, p4);
        gen(5, 5, 1);
        check("t3 pulse after recovery", pulse4, p4 + 1);
        check("t3 period after recovery", last_per4, 10);
        check("t3 high after recovery", last_hi4, 5);

        // Enable dropped mid-period for 3 cycles.
        hold(1'b1, 5);
        hold(1'b0, 2);
        p0 = pulse16;
        sp = per16;
        sh = hi16;
        enable = 1'b0;
        hold(1'b0, 3);
        check("t4 period holds while disabled", per16, sp);
        enable = 1'b1;
        gen(5, 5, 1);
        check("t4 no pulse", pulse16, p0);
        check("t4 period holds", per16, sp);
        check("t4 high holds", hi16, sh);
        gen(5, 5, 1);
        check("t4 pulse on second rise", pulse16, p0 + 1);
        check("t4 period", last_per16, 10);

        // Reset mid-measurement.
        hold(1'b1, 5);
        hold(1'b0, 2);
        reset = 1'b1;
        hold(1'b0, 1);
        check("t5 period zero", per16, 0);
        check("t5 high zero", hi16, 0);
        check("t5 dut4 period zero", per4, 0);
        check("t5 stuck zero", st16, 0);
        reset = 1'b0;
        hold(1'b0, 2);
        p0 = pulse16;
        gen(5, 5, 1);
        check("t5 no pulse on first rise", pulse16, p0);
        gen(5, 5, 1);
        check("t5 pulse on second rise", pulse16, p0 + 1);
        check("t5 period", last_per16, 10);
        check("t5 high", last_hi16, 5);

        // One-cycle glitch at clk/20.
        gen(1, 19, 3);
        check("t6 period", last_per16, 20);
        check("t6 high_time", last_hi16, 1);

        hold(1'b0, 4);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
